// File: rtl/bitrev_pkg.sv
// Shared types and helpers for the bit-reversal reorder controller.
// Optional frame marker (dout_last) is enabled by defining BITREV_LAST_EN.
package bitrev_pkg;

    localparam int FFT_LEN_DEF = 8;
    localparam int ADDR_W_DEF  = $clog2(FFT_LEN_DEF);

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_e;

    // Index width for a frame of n samples; never below one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [31:0] bitrev(input logic [31:0] k, input int width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < width; i++) begin
            r[i] = k[width-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/bitrev_pingpong_ram.sv
// Two-bank sample store: one write port, one read port with a registered
// output; the bank bit is the address MSB.
module bitrev_pingpong_ram
    import bitrev_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16,
    localparam int IW   = addr_w(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic             wbank_i,
    input  logic [IW-1:0]    widx_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic             rbank_i,
    input  logic [IW-1:0]    ridx_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [2*DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[{wbank_i, widx_i}] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[{rbank_i, ridx_i}];
        end
    end

endmodule

// File: rtl/bitrev_reorder_ctrl.sv
// Ping-pong reorder controller: frames written in natural order, read back
// bit-reversed. Define BITREV_LAST_EN to add the dout_last frame marker.
module bitrev_reorder_ctrl
    import bitrev_pkg::*;
#(
    parameter int FFT_LEN = 8,
    parameter int WIDTH   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din_data,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] dout_data,
    output logic             dout_valid,
    input  logic             dout_ready
`ifdef BITREV_LAST_EN
    ,
    output logic             dout_last
`endif
);

    localparam int AW = addr_w(FFT_LEN);
`ifdef BITREV_LAST_EN
    localparam int EW = WIDTH + 1;
`else
    localparam int EW = WIDTH;
`endif
    localparam logic [AW-1:0] K_LAST = AW'(FFT_LEN - 1);

    bank_state_e      bank_q [2];
    bank_state_e      bank_d [2];
    logic [AW-1:0]    wk_q, wk_d, rk_q, rk_d;
    logic             wbank_q, wbank_d, rbank_q, rbank_d;
    logic             rd_vld_q;
    logic [1:0]       skid_cnt_q, skid_cnt_d;
    logic [EW-1:0]    skid_q [2];
    logic [EW-1:0]    skid_d [2];
    logic [WIDTH-1:0] ram_rdata;
    logic [EW-1:0]    rd_ent;
    logic             wr_fire, wr_last, rd_ok, rd_issue, rd_last, pop;
    logic [2:0]       occ;
    logic [AW-1:0]    raddr;

    bitrev_pingpong_ram #(
        .DEPTH (FFT_LEN),
        .WIDTH (WIDTH)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wr_fire),
        .wbank_i (wbank_q),
        .widx_i  (wk_q),
        .wdata_i (din_data),
        .re_i    (rd_issue),
        .rbank_i (rbank_q),
        .ridx_i  (raddr),
        .rdata_o (ram_rdata)
    );

`ifdef BITREV_LAST_EN
    logic rd_last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_last_q <= 1'b0;
        end else if (rd_issue) begin
            rd_last_q <= rd_last;
        end
    end

    assign rd_ent    = {rd_last_q, ram_rdata};
    assign dout_last = skid_q[0][WIDTH];
`else
    assign rd_ent = ram_rdata;
`endif

    assign dout_data  = skid_q[0][WIDTH-1:0];
    assign dout_valid = (skid_cnt_q != 2'd0);
    assign din_ready  = (bank_q[wbank_q] == BANK_EMPTY) || (bank_q[wbank_q] == BANK_FILLING);

    always_comb begin
        wr_fire = din_valid && din_ready;
        wr_last = (wk_q == K_LAST);
        rd_last = (rk_q == K_LAST);
        pop     = dout_valid && dout_ready;
        raddr   = AW'(bitrev(32'(rk_q), AW));
        rd_ok   = (bank_q[rbank_q] == BANK_FULL) || (bank_q[rbank_q] == BANK_DRAINING);
        // A read may issue if skid + in-flight read still fit after this cycle's pop.
        occ      = 3'(skid_cnt_q) + 3'(rd_vld_q) - 3'(pop);
        rd_issue = rd_ok && (occ < 3'd2);

        wk_d    = wr_fire ? wk_q + 1'b1 : wk_q;
        wbank_d = (wr_fire && wr_last) ? ~wbank_q : wbank_q;
        rk_d    = rd_issue ? rk_q + 1'b1 : rk_q;
        rbank_d = (rd_issue && rd_last) ? ~rbank_q : rbank_q;

        // Write and read sides always own different banks, so both may move at once.
        for (int b = 0; b < 2; b++) begin
            bank_d[b] = bank_q[b];
            if (wr_fire && (wbank_q == 1'(b))) begin
                bank_d[b] = wr_last ? BANK_FULL : BANK_FILLING;
            end
            if (rd_issue && (rbank_q == 1'(b))) begin
                bank_d[b] = rd_last ? BANK_EMPTY : BANK_DRAINING;
            end
        end
    end

    always_comb begin
        skid_cnt_d = skid_cnt_q;
        skid_d     = skid_q;
        case ({rd_vld_q, pop})
            2'b10: begin
                skid_d[skid_cnt_q[0]] = rd_ent;
                skid_cnt_d            = skid_cnt_q + 2'd1;
            end
            2'b01: begin
                skid_d[0]  = skid_q[1];
                skid_cnt_d = skid_cnt_q - 2'd1;
            end
            2'b11: begin
                if (skid_cnt_q == 2'd1) begin
                    skid_d[0] = rd_ent;
                end else begin
                    skid_d[0] = skid_q[1];
                    skid_d[1] = rd_ent;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q     <= '{BANK_EMPTY, BANK_EMPTY};
            wk_q       <= '0;
            rk_q       <= '0;
            wbank_q    <= 1'b0;
            rbank_q    <= 1'b0;
            rd_vld_q   <= 1'b0;
            skid_cnt_q <= 2'd0;
            skid_q     <= '{default: '0};
        end else begin
            bank_q     <= bank_d;
            wk_q       <= wk_d;
            rk_q       <= rk_d;
            wbank_q    <= wbank_d;
            rbank_q    <= rbank_d;
            rd_vld_q   <= rd_issue;
            skid_cnt_q <= skid_cnt_d;
            skid_q     <= skid_d;
        end
    end

endmodule

// File: tb/tb_bitrev_reorder_ctrl.sv
// Self-checking bench for bitrev_reorder_ctrl (FFT_LEN=8, WIDTH=16).
module tb_bitrev_reorder_ctrl;

    localparam int N  = 8;
    localparam int W  = 16;
    localparam int LG = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] din_data = '0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic [W-1:0] dout_data;
    logic         dout_valid;
    logic         dout_ready = 1'b1;
`ifdef BITREV_LAST_EN
    logic         dout_last;
`endif

    bitrev_reorder_ctrl #(.FFT_LEN(N), .WIDTH(W)) dut (
`ifdef BITREV_LAST_EN
        .dout_last  (dout_last),
`endif
        .clk        (clk),
        .rst        (rst),
        .din_data   (din_data),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout_data  (dout_data),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    typedef struct {
        logic [W-1:0] din;
        logic [W-1:0] dout;
    } vec_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    vec_t         tbl[N];
    int           out_log[$];
    int           out_cyc[$];
    logic [W-1:0] fbuf[N];
    int           errors = 0, checks = 0;
    int           cyc = 0, fcnt = 0, total_in = 0, total_out = 0, stalls = 0;
    int           last_in_edge = -1, first_out_cyc = -1;
    int           rmode = 0;
    bit           prev_stall = 0;
    logic [W-1:0] prev_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // 0: always ready, 1: never ready, 2: random 50%
    initial forever begin
        @(posedge clk);
        #1;
        case (rmode)
            0:       dout_ready = 1'b1;
            1:       dout_ready = 1'b0;
            default: dout_ready = 1'($urandom_range(1, 0));
        endcase
    end

    function automatic int brev(input int k);
        int r = 0;
        for (int i = 0; i < LG; i++)
            if ((k >> i) & 1) r = r | (1 << (LG - 1 - i));
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", int'(dout_valid), 1);
                chk("hold_data", int'(dout_data), int'(prev_data));
            end
            if (din_valid && din_ready) begin
                fbuf[fcnt] = din_data;
                fcnt++;
                total_in++;
                if (fcnt == N) begin
                    for (int j = 0; j < N; j++) begin
                        mon_e.data = fbuf[brev(j)];
                        mon_e.last = (j == N - 1);
                        exp_q.push_back(mon_e);
                    end
                    fcnt = 0;
                    last_in_edge = cyc + 1;
                end
            end
            if (dout_valid && dout_ready) begin
                total_out++;
                out_log.push_back(int'(dout_data));
                out_cyc.push_back(cyc);
                if (first_out_cyc < 0) first_out_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", int'(dout_data), -1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("dout_data", int'(dout_data), int'(mon_e.data));
`ifdef BITREV_LAST_EN
                    chk("dout_last", int'(dout_last), int'(mon_e.last));
`endif
                end
            end
            prev_stall = dout_valid && !dout_ready;
            prev_data  = dout_data;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        din_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_din_ready", int'(din_ready), 1);
        chk("rst_dout_valid", int'(dout_valid), 0);
        chk("rst_dout_data", int'(dout_data), 0);
`ifdef BITREV_LAST_EN
        chk("rst_dout_last", int'(dout_last), 0);
`endif
        exp_q.delete();
        out_log.delete();
        out_cyc.delete();
        fcnt = 0; total_in = 0; total_out = 0; stalls = 0;
        first_out_cyc = -1; last_in_edge = -1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_one(input int v, input bit gaps);
        bit acc;
        int w;
        if (gaps) begin
            while ($urandom_range(1, 0) == 1) begin
                din_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        din_valid = 1'b1;
        din_data  = W'(v);
        acc = 0;
        w   = 0;
        while (!acc && w < 500) begin
            @(negedge clk);
            acc = din_ready;
            @(posedge clk);
            #1;
            w++;
        end
        if (!acc) chk("din_timeout", 0, 1);
        else if (w > 1) stalls++;
    endtask

    task automatic wait_drain(input int bound);
        int w = 0;
        din_valid = 1'b0;
        while ((exp_q.size() != 0 || dout_valid) && w < bound) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("drain_done", exp_q.size(), 0);
    endtask

    task automatic check_tbl(input string nm);
        chk({nm, "_count"}, out_log.size(), N);
        for (int i = 0; i < N; i++)
            if (i < out_log.size()) chk(nm, out_log[i], int'(tbl[i].dout));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int nxt;
        bit acc;
        int f1[N] = '{8, 12, 10, 14, 9, 13, 11, 15};
        int r0[N] = '{0, 4, 2, 6, 1, 5, 3, 7};
        for (int i = 0; i < N; i++) begin
            tbl[i].din  = W'(i);
            tbl[i].dout = W'(r0[i]);
        end

        // single frame, latency and order
        do_reset();
        rmode = 0;
        for (int i = 0; i < N; i++) send_one(int'(tbl[i].din), 0);
        wait_drain(50);
        check_tbl("frame0_order");
        chk("first_latency", first_out_cyc - last_in_edge, 2);

        // four back-to-back frames
        do_reset();
        for (int i = 0; i < 4 * N; i++) send_one(i, 0);
        wait_drain(100);
        chk("b2b_in_stalls", stalls, 0);
        chk("b2b_out_count", total_out, 4 * N);
        if (out_cyc.size() == 4 * N) chk("b2b_no_gaps", out_cyc[4*N-1] - out_cyc[0], 4 * N - 1);
        for (int i = 0; i < N; i++)
            if (N + i < out_log.size()) chk("b2b_frame1", out_log[N+i], f1[i]);

        // consumer stalled while three frames offered
        do_reset();
        rmode = 1;
        dout_ready = 1'b0;
        nxt = 0;
        din_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            din_data = W'(nxt);
            @(negedge clk);
            acc = din_ready;
            @(posedge clk);
            #1;
            if (acc) nxt++;
        end
        din_valid = 1'b0;
        chk("stall_accepted", total_in, 2 * N);
        chk("stall_din_ready", int'(din_ready), 0);
        chk("stall_dout_valid", int'(dout_valid), 1);
        chk("stall_head", int'(dout_data), 0);
        rmode = 0;
        wait_drain(100);
        chk("stall_drained", total_out, 2 * N);

        // random valid/ready, 100 frames
        do_reset();
        rmode = 2;
        for (int f = 0; f < 100; f++)
            for (int i = 0; i < N; i++) send_one(f * N + i, 1);
        wait_drain(3000);
        chk("rand_in_count", total_in, 100 * N);
        chk("rand_out_count", total_out, 100 * N);

        // reset mid-frame, then a clean frame
        rmode = 0;
        do_reset();
        for (int i = 0; i < 2 * N + 5; i++) send_one(i + 100, 0);
        din_valid = 1'b0;
        chk("pre_rst_valid", int'(dout_valid), 1);
        do_reset();
        for (int i = 0; i < N; i++) send_one(int'(tbl[i].din), 0);
        wait_drain(50);
        check_tbl("post_rst_order");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bitrev_reorder_ctrl.md
# bitrev_reorder_ctrl

Streaming reorder controller that sequences a ping-pong sample buffer so frames written in natural order are read out in bit-reversed order. It sits between the polyphase FFT stage and downstream consumers and converts FFT bin order in either direction. One bank fills while the other drains, sustaining one sample per cycle with valid/ready flow control on both sides.

## Interface

- FFT_LEN, 8, frame length; power of two, >= 2
- WIDTH, 16, sample width in bits
- clk  input  1  system clock; all logic on posedge
- rst  input  1  reset, synchronous, active-high
- din_data  input  WIDTH  input sample, natural order
- din_valid  input  1  input sample present
- din_ready  output  1  controller can accept a sample
- dout_data  output  WIDTH  output sample, bit-reversed order
- dout_valid  output  1  output sample present
- dout_ready  input  1  consumer accepts sample
- dout_last  output  1  last sample of a frame (only with BITREV_LAST_EN)

## Operation

- Input transfer on din_valid && din_ready; output transfer on dout_valid && dout_ready.
- Two banks of FFT_LEN entries, each with a state: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
- Write side: write counter wk (log2(FFT_LEN) bits) addresses bank wbank at wk. On transfer with wk == FFT_LEN-1: wk wraps to 0, bank -> FULL, wbank toggles.
- din_ready = 1 while bank wbank is EMPTY or FILLING; 0 when both banks are FULL/DRAINING.
- Read side: read counter rk; read address = bitrev(rk) in bank rbank. Reads issue only when bank rbank is FULL/DRAINING and the output pipeline has space. On the read issue with rk == FFT_LEN-1: rk wraps, bank -> EMPTY, rbank toggles.
- Simultaneous write-completion on one bank and drain-completion on the other: both transitions occur in the same cycle; no sample lost or duplicated.
- Back-pressure: dout_data/dout_valid (and dout_last) hold stable while dout_valid && !dout_ready. A 2-entry output skid absorbs the in-flight RAM read so no read is stalled mid-pipeline.
- Input stalls (din_valid low) mid-frame pause wk; frame completion is per sample count, not per cycle.
- Reset (any time, including mid-frame): both banks EMPTY, wk = rk = 0, wbank = rbank = 0, skid emptied; partial frames discarded.

## Timing

- Reset values: din_ready = 1, dout_valid = 0, dout_data = 0, dout_last = 0, from the cycle after rst sampled high.
- Latency: with read side idle and dout_ready high, first output sample of frame n is valid 2 cycles after the clock edge accepting that frame's last input sample.
- Throughput: continuous din_valid and dout_ready give one sample in and one out per cycle with no bubbles after the first frame.
- din_ready depends only on registered state (no combinational path from dout_ready).

## Configuration

- BITREV_LAST_EN defined: dout_last port exists and is high exactly on the output sample read from rk == FFT_LEN-1; held with data under back-pressure.
- Undefined: dout_last port absent; no frame-marker logic; all other behaviour identical.

## Structure

- Package bitrev_pkg: function bitrev(k, width) (bit reversal of the index), bank-state enum typedef, localparam computing log2(FFT_LEN) address width.
- Sub-module bitrev_pingpong_ram: 2*FFT_LEN x WIDTH, one write port, one read port with registered output (1-cycle read latency); bank selects the address MSB.
- Controller, counters, and skid buffer live in bitrev_reorder_ctrl.

## Test plan

- FFT_LEN=8, din 0..7 continuous, dout_ready=1 -> dout 0,4,2,6,1,5,3,7; first dout_valid 2 cycles after sample 7 accepted.
- Four back-to-back frames 0..31, dout_ready=1 -> each frame bit-reversed (frame 1: 8,12,10,14,9,13,11,15), no gaps, din_ready never drops.
- dout_ready=0 held while 3 frames offered -> 16 samples accepted, din_ready low from then on; release -> 16 samples drained in order, dout stable during stall.
- Random din_valid/dout_ready (50%), 100 frames -> scoreboard matches bitrev order, no loss or duplication.
- rst asserted after 5 samples of frame 2 -> next cycle dout_valid=0, din_ready=1; new frame 0..7 outputs 0,4,2,6,1,5,3,7.
- BITREV_LAST_EN defined -> dout_last high only with outputs 7, 15, 23; undefined -> build succeeds without the port.
